// File: rtl/p1v_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : p1v_reset_seq
// Brief    : P1V core reset sequencer. Waits for PLL lock, merges the debounced
//            tactile switch and the Prop-plug reset into one minimum-width,
//            synchronously released reset, and records cause and event count.
//            Optional Prop-plug path: define P1V_PLUG_RESET_EN.
// Revision : 1.0  initial release
// ============================================================================
module p1v_reset_seq #(
    parameter int unsigned DEBOUNCE_CYCLES  = 160000,
    parameter int unsigned MIN_RESET_CYCLES = 16000
) (
    input  logic       clock_160,
    input  logic       inp_res,
    input  logic       pll_locked,
    input  logic       tact_n,
    input  logic       plug_resn,
    output logic       res_out_n,
    output logic       pins_safe,
    output logic [1:0] res_cause,
    output logic [7:0] res_count
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(MIN_RESET_CYCLES);
    localparam logic [DEB_W-1:0]  C_DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MIN_RESET_CYCLES - 1);

    localparam logic [1:0] C_CAUSE_SWITCH = 2'd1;
    localparam logic [1:0] C_CAUSE_PLUG   = 2'd2;
    localparam logic [1:0] C_CAUSE_LOCK   = 2'd3;

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------------
    logic [1:0] lock_sync_q;
    logic [1:0] tact_sync_q;
    logic       w_lock_lost;
    logic       w_plug;
    logic       w_sw;

    always_ff @(posedge clock_160 or posedge inp_res) begin
        if (inp_res) begin
            lock_sync_q <= 2'b00;
            tact_sync_q <= 2'b11;
        end else begin
            lock_sync_q <= {lock_sync_q[0], pll_locked};
            tact_sync_q <= {tact_sync_q[0], tact_n};
        end
    end

    assign w_lock_lost = ~lock_sync_q[1];

`ifdef P1V_PLUG_RESET_EN
    logic [1:0] plug_sync_q;

    always_ff @(posedge clock_160 or posedge inp_res) begin
        if (inp_res) begin
            plug_sync_q <= 2'b11;
        end else begin
            plug_sync_q <= {plug_sync_q[0], plug_resn};
        end
    end

    assign w_plug = ~plug_sync_q[1];
`else
    logic unused_plug_resn;
    assign unused_plug_resn = plug_resn;
    assign w_plug           = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Switch debounce: level flips on the Nth consecutive differing sample
    // ------------------------------------------------------------------------
    logic             deb_level_q, deb_level_d;
    logic [DEB_W-1:0] deb_cnt_q,   deb_cnt_d;

    always_comb begin
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        if (tact_sync_q[1] != deb_level_q) begin
            if (deb_cnt_q == C_DEB_LAST) begin
                deb_level_d = ~deb_level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_160 or posedge inp_res) begin
        if (inp_res) begin
            deb_level_q <= 1'b1;
            deb_cnt_q   <= '0;
        end else begin
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
        end
    end

    assign w_sw = ~deb_level_q;

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]        cause_q,    cause_d;
    logic [7:0]        count_q,    count_d;
    logic [7:0]        w_count_inc;
    logic              res_out_n_q;
    logic              pins_safe_q;

    assign w_count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cause_d    = cause_q;
        count_d    = count_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!w_lock_lost) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                // Any active trigger restarts the minimum-width window
                if (w_lock_lost) begin
                    state_d = ST_WAIT_LOCK;
                end else if (w_plug || w_sw) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == C_HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (w_lock_lost) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = C_CAUSE_LOCK;
                    count_d = w_count_inc;
                end else if (w_plug) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    cause_d    = C_CAUSE_PLUG;
                    count_d    = w_count_inc;
                end else if (w_sw) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    cause_d    = C_CAUSE_SWITCH;
                    count_d    = w_count_inc;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clock_160 or posedge inp_res) begin
        if (inp_res) begin
            state_q     <= ST_RESET;
            hold_cnt_q  <= '0;
            cause_q     <= 2'd0;
            count_q     <= 8'd0;
            res_out_n_q <= 1'b0;
            pins_safe_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cause_q     <= cause_d;
            count_q     <= count_d;
            res_out_n_q <= (state_q == ST_RUN);
            pins_safe_q <= (state_q != ST_RUN);
        end
    end

    assign res_out_n = res_out_n_q;
    assign pins_safe = pins_safe_q;
    assign res_cause = cause_q;
    assign res_count = count_q;

endmodule
`default_nettype wire
